// File: rtl/ps2_key_source.sv
// ps2_key_source: PS/2 scan-code set 2 receiver and ASCII decoder feeding the
// text renderer's character-entry interface. Runs entirely in iVGA_CLK.
//
// Ports:
//   iVGA_CLK       system/pixel clock
//   iRST_n         asynchronous active-low reset
//   ps2_clk        raw PS/2 clock (asynchronous)
//   ps2_data       raw PS/2 data (asynchronous)
//   KeyboardInput  ASCII of the last accepted character
//   AdvanceCursor  cursor-advance strobe, ADV_PULSE_CYCLES wide
//   scan_code      last good received byte
//   scan_valid     1-cycle pulse per good frame
//   frame_err      1-cycle pulse on parity, stop or timeout error
//   shift_active   high while either shift key is held
//
// Optional build macro KBD_TYPEMATIC_FILTER_EN: when defined, a make code that
// repeats the previous make code without an intervening break of that key
// produces no character (keyboard auto-repeat suppressed).
module ps2_key_source #(
  parameter int unsigned FILTER_LEN       = 8,
  parameter int unsigned TIMEOUT_CYCLES   = 50000,
  parameter int unsigned ADV_PULSE_CYCLES = 16
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] KeyboardInput,
  output logic       AdvanceCursor,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic       shift_active
);

  localparam int unsigned FiltW    = $clog2(FILTER_LEN + 1);
  localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned AdvW     = $clog2(ADV_PULSE_CYCLES + 1);

  localparam logic [7:0] CodeBreak  = 8'hF0;
  localparam logic [7:0] CodeExt    = 8'hE0;
  localparam logic [7:0] CodeShiftL = 8'h12;
  localparam logic [7:0] CodeShiftR = 8'h59;

  // ---------------------------------------------------------------------------
  // Synchronisers and clock filter
  // ---------------------------------------------------------------------------
  logic [1:0]       clk_sync_q, data_sync_q;
  logic             clk_s, data_s;
  logic             filt_clk_q, filt_clk_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             filt_edge, filt_fall;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // Idle PS/2 lines are high, so sync/filter state resets high to avoid a
  // spurious falling edge after reset.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  // Count consecutive samples that differ from the accepted level; flip on the
  // FILTER_LEN-th one. Any agreeing sample restarts the count.
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_s != filt_clk_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_s;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign filt_edge = (filt_clk_d != filt_clk_q);
  assign filt_fall = filt_edge & filt_clk_q;

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RxIdle, RxData, RxParity, RxStop} rx_state_e;

  rx_state_e           rx_state_q, rx_state_d;
  logic [7:0]          rx_shift_q, rx_shift_d;
  logic [2:0]          rx_bit_cnt_q, rx_bit_cnt_d;
  logic [TimeoutW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                timeout_hit, par_ok;
  logic                rx_good, rx_err;
  logic [7:0]          scan_code_q;
  logic                scan_valid_q, frame_err_q;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rx_state_q <= RxIdle;
    end else begin
      rx_state_q <= rx_state_d;
    end
  end

  assign timeout_hit = (rx_state_q != RxIdle) && !filt_edge &&
                       (tmo_cnt_q == TimeoutW'(TIMEOUT_CYCLES - 1));
  assign par_ok      = ^{rx_shift_q, data_s};

  always_comb begin
    rx_state_d = rx_state_q;
    if (timeout_hit) begin
      rx_state_d = RxIdle;
    end else if (filt_fall) begin
      case (rx_state_q)
        RxIdle:   if (!data_s) rx_state_d = RxData;
        RxData:   if (rx_bit_cnt_q == 3'd7) rx_state_d = RxParity;
        RxParity: rx_state_d = par_ok ? RxStop : RxIdle;
        RxStop:   rx_state_d = RxIdle;
        default:  rx_state_d = RxIdle;
      endcase
    end
  end

  always_comb begin
    rx_good = !timeout_hit && filt_fall && (rx_state_q == RxStop) && data_s;
    rx_err  = timeout_hit ||
              (filt_fall && (rx_state_q == RxParity) && !par_ok) ||
              (filt_fall && (rx_state_q == RxStop) && !data_s);
  end

  always_comb begin
    rx_shift_d   = rx_shift_q;
    rx_bit_cnt_d = rx_bit_cnt_q;
    if (filt_fall) begin
      if (rx_state_q == RxIdle) begin
        rx_bit_cnt_d = '0;
      end else if (rx_state_q == RxData) begin
        rx_shift_d   = {data_s, rx_shift_q[7:1]};
        rx_bit_cnt_d = rx_bit_cnt_q + 1'b1;
      end
    end
    // Timeout counter only runs inside a frame and restarts on every edge.
    if ((rx_state_q == RxIdle) || filt_edge) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rx_shift_q   <= '0;
      rx_bit_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_shift_q   <= rx_shift_d;
      rx_bit_cnt_q <= rx_bit_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      scan_code_q  <= rx_good ? rx_shift_q : scan_code_q;
      scan_valid_q <= rx_good;
      frame_err_q  <= rx_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Decoder FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {DIdle, DBreak, DExt, DExtBreak} dec_state_e;

  dec_state_e dec_state_q, dec_state_d;
  logic       shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic       char_valid;
  logic [7:0] char_code;
  logic [8:0] mapped;
`ifdef KBD_TYPEMATIC_FILTER_EN
  logic [7:0] last_make_q, last_make_d;
`endif

  // Returns {valid, ascii} for a make code under the given shift state.
  function automatic logic [8:0] map_code(input logic [7:0] code, input logic shift);
    logic [7:0] ltr;
    ltr      = 8'h00;
    map_code = 9'h000;
    case (code)
      8'h1C: ltr = 8'h61;
      8'h32: ltr = 8'h62;
      8'h21: ltr = 8'h63;
      8'h23: ltr = 8'h64;
      8'h24: ltr = 8'h65;
      8'h2B: ltr = 8'h66;
      8'h34: ltr = 8'h67;
      8'h33: ltr = 8'h68;
      8'h43: ltr = 8'h69;
      8'h3B: ltr = 8'h6A;
      8'h42: ltr = 8'h6B;
      8'h4B: ltr = 8'h6C;
      8'h3A: ltr = 8'h6D;
      8'h31: ltr = 8'h6E;
      8'h44: ltr = 8'h6F;
      8'h4D: ltr = 8'h70;
      8'h15: ltr = 8'h71;
      8'h2D: ltr = 8'h72;
      8'h1B: ltr = 8'h73;
      8'h2C: ltr = 8'h74;
      8'h3C: ltr = 8'h75;
      8'h2A: ltr = 8'h76;
      8'h1D: ltr = 8'h77;
      8'h22: ltr = 8'h78;
      8'h35: ltr = 8'h79;
      8'h1A: ltr = 8'h7A;
      8'h45: map_code = {1'b1, 8'h30};
      8'h16: map_code = {1'b1, 8'h31};
      8'h1E: map_code = {1'b1, 8'h32};
      8'h26: map_code = {1'b1, 8'h33};
      8'h25: map_code = {1'b1, 8'h34};
      8'h2E: map_code = {1'b1, 8'h35};
      8'h36: map_code = {1'b1, 8'h36};
      8'h3D: map_code = {1'b1, 8'h37};
      8'h3E: map_code = {1'b1, 8'h38};
      8'h46: map_code = {1'b1, 8'h39};
      8'h4E: if (!shift) map_code = {1'b1, 8'h2D};
      8'h55: if (!shift) map_code = {1'b1, 8'h3D};
      8'h29: if (!shift) map_code = {1'b1, 8'h20};
      8'h5D: if (shift) map_code = {1'b1, 8'h7C};
      default: ;
    endcase
    if (ltr != 8'h00) begin
      map_code = {1'b1, (shift ? ltr - 8'h20 : ltr)};
    end
  endfunction

  assign mapped = map_code(scan_code_q, shift_l_q | shift_r_q);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      dec_state_q <= DIdle;
    end else begin
      dec_state_q <= dec_state_d;
    end
  end

  always_comb begin
    dec_state_d = dec_state_q;
    if (scan_valid_q) begin
      case (dec_state_q)
        DIdle: begin
          if (scan_code_q == CodeBreak)    dec_state_d = DBreak;
          else if (scan_code_q == CodeExt) dec_state_d = DExt;
        end
        DExt:    dec_state_d = (scan_code_q == CodeBreak) ? DExtBreak : DIdle;
        default: dec_state_d = DIdle;
      endcase
    end
  end

  always_comb begin
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    char_valid  = 1'b0;
    char_code   = mapped[7:0];
`ifdef KBD_TYPEMATIC_FILTER_EN
    last_make_d = last_make_q;
`endif
    if (scan_valid_q) begin
      if (dec_state_q == DIdle && scan_code_q != CodeBreak && scan_code_q != CodeExt) begin
        if (scan_code_q == CodeShiftL) shift_l_d = 1'b1;
        if (scan_code_q == CodeShiftR) shift_r_d = 1'b1;
`ifdef KBD_TYPEMATIC_FILTER_EN
        char_valid  = mapped[8] && (scan_code_q != last_make_q);
        last_make_d = scan_code_q;
`else
        char_valid  = mapped[8];
`endif
      end else if (dec_state_q == DBreak) begin
        if (scan_code_q == CodeShiftL) shift_l_d = 1'b0;
        if (scan_code_q == CodeShiftR) shift_r_d = 1'b0;
`ifdef KBD_TYPEMATIC_FILTER_EN
        if (scan_code_q == last_make_q) last_make_d = 8'h00;
`endif
      end
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
`ifdef KBD_TYPEMATIC_FILTER_EN
      last_make_q <= 8'h00;
`endif
    end else begin
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
`ifdef KBD_TYPEMATIC_FILTER_EN
      last_make_q <= last_make_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Character output and cursor strobe
  // ---------------------------------------------------------------------------
  logic [7:0]      kbd_q, kbd_d;
  logic            pending_q, pending_d;
  logic            adv_q, adv_d;
  logic [AdvW-1:0] adv_cnt_q, adv_cnt_d;
  logic            accept;

  // pending_q marks the cycle before the strobe rises; characters arriving
  // then or while the strobe is high are dropped.
  assign accept = char_valid && !pending_q && !adv_q;

  always_comb begin
    kbd_d     = accept ? char_code : kbd_q;
    pending_d = accept;
    adv_d     = adv_q;
    adv_cnt_d = adv_cnt_q;
    if (pending_q) begin
      adv_d     = 1'b1;
      adv_cnt_d = '0;
    end else if (adv_q) begin
      if (adv_cnt_q == AdvW'(ADV_PULSE_CYCLES - 1)) begin
        adv_d     = 1'b0;
        adv_cnt_d = '0;
      end else begin
        adv_cnt_d = adv_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      kbd_q     <= '0;
      pending_q <= 1'b0;
      adv_q     <= 1'b0;
      adv_cnt_q <= '0;
    end else begin
      kbd_q     <= kbd_d;
      pending_q <= pending_d;
      adv_q     <= adv_d;
      adv_cnt_q <= adv_cnt_d;
    end
  end

  assign KeyboardInput = kbd_q;
  assign AdvanceCursor = adv_q;
  assign scan_code     = scan_code_q;
  assign scan_valid    = scan_valid_q;
  assign frame_err     = frame_err_q;
  assign shift_active  = shift_l_q | shift_r_q;

endmodule
